// File: rtl/accum_pkg.sv
// Shared types and widths for the frame accumulator and its adder.
package accum_pkg;

    localparam int DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } accum_state_t;

endpackage

// File: rtl/adder_4bit.sv
// Combinational 4-bit ripple-carry adder with carry in and carry out.
import accum_pkg::*;

module adder_4bit (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);

    logic [DATA_W:0] carry;

    // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < DATA_W; i++) begin
            sum[i]     = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
        end
    end

    assign cout = carry[DATA_W];

endmodule

// File: rtl/accumulator_4bit.sv
// Frame accumulator: sums FRAME_LEN operands through adder_4bit, counts adder
// overflows, and hands the frame result downstream over valid/ready.
import accum_pkg::*;

module accumulator_4bit #(
    parameter int FRAME_LEN = 4,
    parameter int CNT_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_cin,
    input  logic              abort,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_ovf,
    output logic [CNT_W-1:0]  out_ovf_cnt
);

    accum_state_t      state;
    accum_state_t      state_next;
    logic [DATA_W-1:0] accum;
    logic [DATA_W-1:0] add_a;
    logic [DATA_W-1:0] add_sum;
    logic              add_cout;
    logic [CNT_W-1:0]  op_cnt;
    logic [CNT_W-1:0]  op_cnt_next;
    logic [CNT_W-1:0]  ovf_cnt;
    logic [CNT_W-1:0]  ovf_cnt_next;
    logic              accept;
    logic              consume;
    logic              frame_end;
    logic              dropping;

    // abort withdraws readiness so the operand presented alongside it is never counted
    assign in_ready  = (state != DONE) && !rst && !abort;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign consume   = out_valid && out_ready;
    assign dropping  = (state != DONE) && abort;

    // The first operand of a frame starts from zero regardless of stale accum contents
    assign add_a = (state == IDLE) ? '0 : accum;

    adder_4bit u_adder (
        .a    (add_a),
        .b    (in_data),
        .cin  (in_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        op_cnt_next  = op_cnt + 1'b1;
        ovf_cnt_next = ovf_cnt + CNT_W'(add_cout);
        frame_end    = (op_cnt_next == CNT_W'(FRAME_LEN));
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, ACCUM: begin
                if (abort)       state_next = IDLE;
                else if (accept) state_next = frame_end ? DONE : ACCUM;
            end
            DONE: begin
                if (consume) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            accum       <= '0;
            op_cnt      <= '0;
            ovf_cnt     <= '0;
            out_sum     <= '0;
            out_ovf     <= 1'b0;
            out_ovf_cnt <= '0;
        end else begin
            state <= state_next;
            if (dropping || consume) begin
                accum   <= '0;
                op_cnt  <= '0;
                ovf_cnt <= '0;
            end else if (accept) begin
                accum   <= add_sum;
                op_cnt  <= op_cnt_next;
                ovf_cnt <= ovf_cnt_next;
                // Result registers change only when a frame completes and otherwise hold the last result
                if (frame_end) begin
                    out_sum     <= add_sum;
                    out_ovf     <= (ovf_cnt_next != '0);
                    out_ovf_cnt <= ovf_cnt_next;
                end
            end
        end
    end

endmodule
